// File: rtl/conv_pkg.sv
// Shared convolution constants and the window element indexing used by window_gen and mac.
package conv_pkg;

  localparam int unsigned KernelWidthDefault = 3;
  localparam int unsigned KernelAreaDefault  = KernelWidthDefault * KernelWidthDefault;

  // Flat window element index: row r (0 = oldest line), column c (0 = oldest pixel).
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// Holds the previous Rows lines; one accept reads the column and pushes it down one row.
module window_gen_line_buffer #(
  parameter int unsigned Rows    = 2,
  parameter int unsigned Depth   = 320,
  parameter int unsigned WidthIn = 1,
  localparam int unsigned AddrW  = $clog2(Depth)
) (
  input  logic                          clk_i,
  input  logic                          wr_en,
  input  logic [AddrW-1:0]              addr,
  input  logic [WidthIn-1:0]            din,
  output logic [Rows-1:0][WidthIn-1:0]  dout
);

  // Row 0 is the most recent complete line, row Rows-1 the oldest.
  logic [WidthIn-1:0] mem [Rows][Depth];

  always_comb begin
    dout = '0;
    for (int unsigned r = 0; r < Rows; r++) dout[r] = mem[r][addr];
  end

  // Contents are deliberately unreset; stale rows are never emitted.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[0][addr] <= din;
      for (int unsigned r = 1; r < Rows; r++) mem[r][addr] <= mem[r-1][addr];
    end
  end

endmodule

// File: rtl/window_gen.sv
// Streaming KxK sliding-window generator: raster pixels in, one window per interior position out.
module window_gen
  import conv_pkg::*;
#(
  parameter int unsigned KernelWidth = KernelWidthDefault,
  parameter int unsigned WidthIn     = 1,
  parameter int unsigned LineWidth   = 320,
  parameter int unsigned LineCount   = 240,
  localparam int unsigned KernelArea = KernelWidth * KernelWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [WidthIn-1:0]                  pixel_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  output logic [KernelArea-1:0][WidthIn-1:0]  window_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                last_o
);

  localparam int unsigned ColW = $clog2(LineWidth);
  localparam int unsigned RowW = $clog2(LineCount);
  localparam int unsigned Edge = KernelWidth - 1;

  logic [ColW-1:0]                     col;
  logic [RowW-1:0]                     row;
  logic [KernelArea-1:0][WidthIn-1:0]  win;
  logic [KernelArea-1:0][WidthIn-1:0]  win_nxt_c;
  logic [KernelWidth-2:0][WidthIn-1:0] lb_col;
  logic                                accept_c;
  logic                                emit_c;
  logic                                col_end_c;
  logic                                row_end_c;

  assign ready_o   = ~valid_o | ready_i;
  assign accept_c  = valid_i & ready_o;
  assign col_end_c = (col == ColW'(LineWidth - 1));
  assign row_end_c = (row == RowW'(LineCount - 1));
  // Only positions with a full KxK neighbourhood inside the current line set emit.
  assign emit_c    = accept_c && (row >= RowW'(Edge)) && (col >= ColW'(Edge));

  window_gen_line_buffer #(
    .Rows    (KernelWidth - 1),
    .Depth   (LineWidth),
    .WidthIn (WidthIn)
  ) u_line_buffer (
    .clk_i (clk_i),
    .wr_en (accept_c),
    .addr  (col),
    .din   (pixel_i),
    .dout  (lb_col)
  );

  // Shift columns left; new right column is buffered lines (oldest on top) plus pixel_i.
  for (genvar r = 0; r < KernelWidth; r++) begin : g_row
    for (genvar c = 0; c < KernelWidth - 1; c++) begin : g_shift
      assign win_nxt_c[idx(r, c, KernelWidth)] = win[idx(r, c + 1, KernelWidth)];
    end
    if (r < KernelWidth - 1) begin : g_buf
      assign win_nxt_c[idx(r, Edge, KernelWidth)] = lb_col[KernelWidth - 2 - r];
    end else begin : g_pix
      assign win_nxt_c[idx(r, Edge, KernelWidth)] = pixel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col      <= '0;
      row      <= '0;
      win      <= '0;
      window_o <= '0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
    end else begin
      if (accept_c) begin
        win <= win_nxt_c;
        if (col_end_c) begin
          col <= '0;
          row <= row_end_c ? '0 : row + RowW'(1);
        end else begin
          col <= col + ColW'(1);
        end
      end
      // A new window may replace one being consumed in the same cycle.
      if (emit_c) begin
        valid_o  <= 1'b1;
        last_o   <= row_end_c & col_end_c;
        window_o <= win_nxt_c;
      end else if (ready_i) begin
        valid_o  <= 1'b0;
        last_o   <= 1'b0;
      end
    end
  end

endmodule
